// File: rtl/constraint_pkg.sv
// constraint_pkg: shared types and constants for the constraint sampler slice
package constraint_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PROPOSE = 2'd1,
        HOLD    = 2'd2,
        FAIL    = 2'd3
    } state_t;

    localparam int LFSR_WIDTH = 29;

    // Taps of x^29 + x^27 + 1 for a right-shifting Galois LFSR
    localparam logic [LFSR_WIDTH-1:0] TAPMASK = 29'h1400_0000;

    localparam logic [LFSR_WIDTH-1:0] DEF_SEED = 29'h1ABC_DEF1;

endpackage

// File: rtl/lfsr29_galois.sv
// lfsr29_galois: 29-bit right-shifting Galois LFSR that can never hold zero
module lfsr29_galois
    import constraint_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = DEF_SEED
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] load_val,
    input  logic                  adv,
    output logic [LFSR_WIDTH-1:0] q
);

    // Load wins over advance; a zero load is replaced by SEED so the register stays nonzero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= SEED;
        else if (load)
            q <= (load_val == '0) ? SEED : load_val;
        else if (adv)
            q <= (q >> 1) ^ (q[0] ? TAPMASK : '0);
    end

endmodule

// File: rtl/constraint_sampler.sv
// constraint_sampler: proposes LFSR candidates until the checker accepts or the try budget runs out
module constraint_sampler
    import constraint_pkg::*;
#(
    parameter int                    WIDTH     = 29,
    parameter int                    MAX_TRIES = 16,
    parameter logic [WIDTH-1:0]      SEED      = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] cand,
    input  logic             cand_ok,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic [WIDTH-1:0] sol_data,
    output logic             busy,
    output logic             fail,
    output logic [15:0]      tries
);

    state_t state;
    logic   idle;
    logic   last;

    assign idle = (state == IDLE);
    assign last = (17'(tries) + 17'd1) == 17'(MAX_TRIES);

    lfsr29_galois #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (idle && seed_load),
        .load_val (seed),
        .adv      (state == PROPOSE),
        .q        (cand)
    );

    // Request FSM with try counter and captured solution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tries    <= '0;
            sol_data <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= PROPOSE;
                    tries <= '0;
                end
                PROPOSE: begin
                    tries <= tries + 16'd1;
                    if (cand_ok) begin
                        sol_data <= cand;
                        state    <= HOLD;
                    end else if (last) begin
                        state <= FAIL;
                    end
                end
                HOLD: if (sol_ready) state <= IDLE;
                FAIL: state <= IDLE;
            endcase
        end
    end

    assign sol_valid = (state == HOLD);
    assign fail      = (state == FAIL);
    assign busy      = !idle;

endmodule

// File: tb/tb_constraint_sampler.sv
// tb_constraint_sampler: randomized self-checking bench against a request-level reference model
module tb_constraint_sampler;

    localparam int          W  = 29;
    localparam int          MT = 16;
    localparam logic [28:0] DS = 29'h1ABC_DEF1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        seed_load = 1'b0;
    logic [28:0] seed = '0;
    logic        sol_ready = 1'b0;
    logic [28:0] cand;
    logic        cand_ok;
    logic        sol_valid;
    logic [28:0] sol_data;
    logic        busy;
    logic        fail;
    logic [15:0] tries;

    int          checks = 0;
    int          errors = 0;
    int          mode = 0;
    logic [28:0] target = '0;
    logic [3:0]  key = '0;
    int          thr = 4;
    logic [28:0] exp_lfsr = DS;
    logic [28:0] exp_data = '0;

    always #5 clk = ~clk;

    constraint_sampler #(.WIDTH(W), .MAX_TRIES(MT), .SEED(DS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed_load (seed_load),
        .seed      (seed),
        .cand      (cand),
        .cand_ok   (cand_ok),
        .sol_valid (sol_valid),
        .sol_ready (sol_ready),
        .sol_data  (sol_data),
        .busy      (busy),
        .fail      (fail),
        .tries     (tries)
    );

    // Stand-in checker: 0 accept nonzero, 1 accept one value, 2 reject all, 3 pseudo-random subset
    assign cand_ok = (mode == 0) ? (cand != '0) :
                     (mode == 1) ? (cand == target) :
                     (mode == 2) ? 1'b0 :
                     (32'(cand[3:0] ^ key) < thr);

    function automatic logic acc(input logic [28:0] v);
        if (mode == 0) return v != '0;
        if (mode == 1) return v == target;
        if (mode == 2) return 1'b0;
        return 32'(v[3:0] ^ key) < thr;
    endfunction

    function automatic logic [28:0] lnext(input logic [28:0] v);
        return (v >> 1) ^ (v[0] ? 29'h1400_0000 : 29'h0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic request(input int delay, input bit poke, input bit do_load, input logic [28:0] ld);
        logic [28:0] v;
        logic [28:0] cands [MT];
        int          k;
        bit          ok;
        @(negedge clk);
        start     = 1'b1;
        seed_load = do_load;
        seed      = ld;
        sol_ready = (delay == 0);
        if (do_load) exp_lfsr = (ld == '0) ? DS : ld;
        v  = exp_lfsr;
        ok = 1'b0;
        k  = MT;
        for (int i = 0; i < MT; i++) begin
            cands[i] = v;
            v = lnext(v);
            if (acc(cands[i])) begin
                ok = 1'b1;
                k  = i + 1;
                break;
            end
        end
        exp_lfsr = v;
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
        for (int n = 1; n <= k; n++) begin
            if (n > 1) @(negedge clk);
            check("prop_busy", 32'(busy), 32'd1);
            check("prop_cand", 32'(cand), 32'(cands[n-1]));
            check("prop_valid", 32'(sol_valid), 32'd0);
            check("prop_fail", 32'(fail), 32'd0);
            check("prop_tries", 32'(tries), 32'(n - 1));
        end
        @(negedge clk);
        if (ok) begin
            exp_data = cands[k-1];
            check("hold_valid", 32'(sol_valid), 32'd1);
            check("hold_data", 32'(sol_data), 32'(exp_data));
            check("hold_tries", 32'(tries), 32'(k));
            check("hold_fail", 32'(fail), 32'd0);
            for (int d = 0; d < delay; d++) begin
                if (poke && d == 0) begin
                    start     = 1'b1;
                    seed_load = 1'b1;
                    seed      = 29'($urandom);
                end
                @(negedge clk);
                start     = 1'b0;
                seed_load = 1'b0;
                check("bp_valid", 32'(sol_valid), 32'd1);
                check("bp_data", 32'(sol_data), 32'(exp_data));
                check("bp_tries", 32'(tries), 32'(k));
                check("bp_cand", 32'(cand), 32'(exp_lfsr));
            end
            sol_ready = 1'b1;
            @(negedge clk);
            check("done_valid", 32'(sol_valid), 32'd0);
            check("done_busy", 32'(busy), 32'd0);
            check("done_cand", 32'(cand), 32'(exp_lfsr));
        end else begin
            check("fail_pulse", 32'(fail), 32'd1);
            check("fail_tries", 32'(tries), 32'(MT));
            check("fail_valid", 32'(sol_valid), 32'd0);
            check("fail_data", 32'(sol_data), 32'(exp_data));
            @(negedge clk);
            check("fail_gone", 32'(fail), 32'd0);
            check("fail_busy", 32'(busy), 32'd0);
            check("fail_tries_keep", 32'(tries), 32'(MT));
        end
        sol_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_cand", 32'(cand), 32'(DS));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(sol_valid), 32'd0);
        check("rst_data", 32'(sol_data), 32'd0);
        check("rst_tries", 32'(tries), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        rst_n = 1'b1;

        mode = 0;
        request(0, 1'b0, 1'b0, '0);
        check("first_sol", 32'(sol_data), 32'(DS));

        @(negedge clk);
        seed_load = 1'b1;
        seed      = '0;
        @(negedge clk);
        seed_load = 1'b0;
        exp_lfsr  = DS;
        check("zero_seed", 32'(cand), 32'(DS));

        mode   = 1;
        target = lnext(lnext(DS));
        request(0, 1'b0, 1'b0, '0);
        check("third_tries", 32'(tries), 32'd3);

        mode = 2;
        request(0, 1'b0, 1'b0, '0);

        mode = 0;
        request(5, 1'b1, 1'b0, '0);

        request(0, 1'b0, 1'b1, 29'h5);
        check("seed5_sol", 32'(sol_data), 32'h5);

        for (int r = 0; r < 25; r++) begin
            mode = 3;
            key  = 4'($urandom);
            thr  = int'($urandom_range(0, 5));
            request(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) == 0) ? 29'h0 : 29'($urandom));
        end

        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cand", 32'(cand), 32'(DS));
        check("arst_tries", 32'(tries), 32'd0);
        check("arst_valid", 32'(sol_valid), 32'd0);
        check("arst_data", 32'(sol_data), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_lfsr = DS;
        exp_data = '0;
        @(negedge clk);
        check("post_busy", 32'(busy), 32'd0);
        check("post_valid", 32'(sol_valid), 32'd0);
        mode = 0;
        request(0, 1'b0, 1'b0, '0);
        check("post_sol", 32'(sol_data), 32'(DS));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/constraint_sampler.md
# constraint_sampler

Sequential candidate generator that drives a single-output constraint checker (e.g. the `split_*` modules) from the opposite side.
- Produces pseudo-random 29-bit candidate assignments and samples the checker's combinational verdict.
- Retries until the constraint holds or a try budget is exhausted.
- Hands accepted solutions downstream over a valid/ready interface.
- Sits between the solver's random-stimulus front end and the per-constraint checker instances.

## Interface
Parameters:
- WIDTH, 29, candidate width; matches the checked variable.
- MAX_TRIES, 16, maximum candidates proposed per request; range 1..65535.
- SEED, 29'h1ABC_DEF1, LFSR reset value and replacement for an all-zero seed; must be nonzero.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request one solution; honoured only in IDLE.
- seed_load  in  1  load `seed` into the LFSR; honoured only in IDLE.
- seed  in  WIDTH  seed value.
- cand  out  WIDTH  current candidate; wired to the checker input.
- cand_ok  in  1  checker verdict for `cand`, combinational, same cycle.
- sol_valid  out  1  `sol_data` holds an accepted solution.
- sol_ready  in  1  downstream accepts.
- sol_data  out  WIDTH  accepted candidate.
- busy  out  1  high in every state except IDLE.
- fail  out  1  one-cycle pulse when the try budget is exhausted.
- tries  out  16  candidates proposed for the current or last request.

## Operation
- LFSR: Galois type, polynomial x^29 + x^27 + 1, shift right. With `lsb = lfsr[0]`, `next = (lfsr >> 1) ^ (lsb ? TAPMASK : 0)`. TAPMASK has bits 28 and 26 set.
- `cand = lfsr` in all states.
- States:
  - IDLE:
    - `seed_load` → `lfsr = (seed == 0) ? SEED : seed`.
    - `start` → PROPOSE and `tries = 0`.
    - If both are high in the same cycle, the load takes effect and `start` is also taken. The first candidate is then the loaded seed.
  - PROPOSE: each cycle, evaluate `cand_ok`.
    - `cand_ok = 1` → `sol_data = lfsr`, `tries = tries + 1`, LFSR advances, → HOLD.
    - `cand_ok = 0` and `tries + 1 == MAX_TRIES` → `tries = MAX_TRIES`, LFSR advances, → FAIL.
    - otherwise → `tries = tries + 1`, LFSR advances, stay in PROPOSE.
  - HOLD: `sol_valid = 1`. `sol_data` and `tries` are stable. `sol_valid && sol_ready` → IDLE.
  - FAIL: `fail = 1` for exactly this cycle, → IDLE. `sol_data` keeps its previous value.
- `start`, `seed_load` and `seed` are ignored outside IDLE.
- `tries` saturates at MAX_TRIES and is never wider than 16 bits.
- The LFSR never holds zero.

## Timing
- Reset values:
  - state = IDLE
  - lfsr = SEED, so cand = SEED
  - sol_valid = 0
  - sol_data = 0
  - busy = 0
  - fail = 0
  - tries = 0
- Reset asserted mid-request aborts immediately to the reset values. There is no pending solution after release.
- Latency for a success on try k (k ≥ 1):
  - `start` sampled at edge 0.
  - PROPOSE occupies cycles 1..k.
  - `sol_valid` rises after edge k+1.
- With an accepting checker, `sol_valid` is high in cycle 2 after `start`.
- Failure: `fail` pulses in cycle MAX_TRIES+1 after `start`.
- Handshake:
  - `sol_valid` stays high with stable data until `sol_ready`. `sol_ready` may be high before `sol_valid`.
  - Transfer completes on the edge where both are high. `sol_valid` is low the next cycle.
- Earliest next `start`: the cycle after return to IDLE. There is no back-to-back overlap.
- `cand_ok` is sampled only in PROPOSE. Its value in other states is don't-care.

## Structure
- Shared package `constraint_pkg`:
  - state enum: IDLE, PROPOSE, HOLD, FAIL
  - LFSR_WIDTH = 29
  - TAPMASK
  - default SEED
- One natural sub-module: `lfsr29_galois`, with ports `clk`, `rst_n`, `load`, `load_val`, `adv`, `q`.
  - Reset value is SEED.
  - Load substitutes SEED for zero.
- FSM, try counter and output register stay in `constraint_sampler`.
- The checker is instantiated outside this block and connected through `cand`/`cand_ok`.

## Test plan
- Accept-all checker (`cand_ok = (cand != 0)`), default SEED, `start` at cycle 0, `sol_ready = 1` → `sol_valid` in cycle 2, `sol_data = 29'h1ABC_DEF1`, `tries = 1`, then IDLE.
- Checker accepting only the third candidate → `sol_data` equals the LFSR value two steps after SEED, `tries = 3`, `sol_valid` in cycle 4.
- Reject-all checker, MAX_TRIES = 16 → exactly 16 distinct candidates, `fail` high only in cycle 17, `tries = 16`, `sol_valid` never set.
- Backpressure: `sol_ready = 0` for 5 cycles after `sol_valid` → `sol_data` and `sol_valid` stable. A `start` pulse during HOLD is ignored. Transfer happens on the first `sol_ready = 1`.
- `seed_load` with `seed = 0` → `cand = SEED`. `seed_load` with `29'h0000_0005` plus `start` in the same cycle → first candidate is `29'h5`.
- `rst_n` asserted in the middle of PROPOSE, asynchronously between edges → outputs reach their reset values before the next edge. `busy = 0` and `cand = SEED` after release.
